// File: rtl/tdm_mux_4to1_rr.sv
// tdm_mux_4to1_rr: round-robin 4-to-1 valid/ready gatherer with a one-word output register tagged by source channel
module tdm_mux_4to1_rr #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_sel,
    input  logic           out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d, sel_q, sel_d, off, g;
    logic [W-1:0]   data_q, data_d;
    logic [3:0]     rot;
    logic           load, grant;
    always_comb begin
        rot      = 4'({in_valid, in_valid} >> ptr_q);
        off      = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        g        = ptr_q + off;
        load     = (state_q == EMPTY) | out_ready;
        grant    = load & rst_n & (|in_valid);
        in_ready = grant ? 4'(1) << g : 4'b0;
        data_d   = grant ? in_data[g*W +: W] : data_q;
        sel_d    = grant ? g : sel_q;
        ptr_d    = grant ? g + 2'd1 : ptr_q;
        state_d  = grant ? FULL : out_ready ? EMPTY : state_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;
endmodule

// File: tb/tb_tdm_mux_4to1_rr.sv
// tb_tdm_mux_4to1_rr: scoreboard bench; a one-slot queue model predicts grants, a monitor checks the output stream
module tb_tdm_mux_4to1_rr;
    localparam int W = 4;
    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } item_t;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     in_valid = 4'b0;
    logic [4*W-1:0] in_data = '0;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready = 1'b0;
    int             errors = 0;
    int             checks = 0;
    item_t          sb[$];
    int             ptr = 0;
    int             last_g = -1;
    int             granted[4];
    int             received[4];
    logic [W-1:0]   y[4];
    logic [3:0]     cur_v = 4'b0;
    logic [4*W-1:0] cur_d = '0;
    always #5 clk = ~clk;
    tdm_mux_4to1_rr #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // The model holds at most one word: the slot is free for a grant once the monitor has retired it.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready && rst_n) begin
            y[out_sel] = out_data;
            received[out_sel]++;
        end
        if (sb.size() != 0) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_sel", 32'(out_sel), 32'(sb[0].sel));
            chk("out_data", 32'(out_data), 32'(sb[0].data));
            if (out_ready) begin
                chk("demux_y", 32'(y[sb[0].sel]), 32'(sb[0].data));
                void'(sb.pop_front());
            end
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
        end
    end
    task automatic step(input logic r, input logic [3:0] v, input logic [4*W-1:0] d, input logic ordy);
        int g;
        g = -1;
        @(posedge clk);
        #1;
        rst_n = r; in_valid = v; in_data = d; out_ready = ordy;
        @(negedge clk);
        #1;
        if (r && sb.size() == 0)
            for (int k = 0; k < 4; k++)
                if (g < 0 && v[(ptr + k) % 4]) g = (ptr + k) % 4;
        chk("in_ready", 32'(in_ready), g < 0 ? 32'd0 : 32'd1 << g);
        if (!r) begin
            foreach (sb[i]) granted[sb[i].sel]--;
            sb.delete();
            ptr = 0;
        end else if (g >= 0) begin
            sb.push_back('{sel: 2'(g), data: d[g*W +: W]});
            ptr = (g + 1) % 4;
            granted[g]++;
        end
        last_g = g;
    endtask
    // Offered words stay put until taken; occasionally a source withdraws, which is tolerated.
    task automatic gen();
        for (int k = 0; k < 4; k++) begin
            if (cur_v[k] && last_g != k && $urandom_range(7) != 0) continue;
            cur_v[k] = 1'($urandom_range(1));
            cur_d[k*W +: W] = W'($urandom);
        end
    endtask
    initial begin
        logic [4*W-1:0] d;
        for (int k = 0; k < 4; k++) begin
            granted[k] = 0; received[k] = 0; y[k] = '0;
        end
        d = 16'h9C35;
        step(0, 4'b1111, d, 1'b0);
        step(0, 4'b1111, d, 1'b0);
        step(1, 4'b0100, d, 1'b1);
        step(1, 4'b0000, d, 1'b1);
        step(0, 4'b0000, d, 1'b0);
        repeat (6) step(1, 4'b1111, d, 1'b1);
        step(0, 4'b0000, d, 1'b0);
        step(1, 4'b0010, d, 1'b1);
        repeat (3) step(1, 4'b1111, d, 1'b0);
        repeat (2) step(1, 4'b1111, d, 1'b1);
        step(0, 4'b0000, d, 1'b0);
        step(1, 4'b0001, d, 1'b1);
        step(1, 4'b0000, d, 1'b1);
        step(1, 4'b0001, d, 1'b1);
        step(1, 4'b0000, d, 1'b0);
        step(0, 4'b1111, d, 1'b0);
        step(1, 4'b0000, d, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            gen();
            if ($urandom_range(199) == 0) step(0, cur_v, cur_d, 1'b0);
            else step(1, cur_v, cur_d, 1'($urandom_range(3) != 0));
        end
        repeat (4) step(1, 4'b0000, cur_d, 1'b1);
        for (int k = 0; k < 4; k++) chk($sformatf("count_ch%0d", k), 32'(received[k]), 32'(granted[k]));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
